lcd_timing_out: RTL and testbench

//  Parametrised RGB-LCD timing generator and output stage for the 10 MHz pixel-clock domain.

---
 rtl/lcd_timing_out.sv | 206 ++++++++++++++++++++
 tb/tb_lcd_timing_out.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lcd_timing_out.sv
// RGB-LCD timing generator and output stage: H/V counters, sync/den generation,
// frame-buffer pixel request, RGB565 widening, test patterns and underflow flag.
module lcd_timing_out #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int OUT_W    = 8,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic             pix_req,
    input  logic [15:0]      pix_data,
    input  logic             pix_valid,
    output logic             frame_start,
    output logic             underflow,
    input  logic             underflow_clr,
    output logic [OUT_W-1:0] lcd_r,
    output logic [OUT_W-1:0] lcd_g,
    output logic [OUT_W-1:0] lcd_b,
    output logic             lcd_hsync,
    output logic             lcd_vsync,
    output logic             lcd_den
);

    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA_START = H_SYNC + H_BP;
    localparam int HA_END   = HA_START + H_ACTIVE;
    localparam int VA_START = V_SYNC + V_BP;
    localparam int VA_END   = VA_START + V_ACTIVE;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    typedef enum logic [1:0] {MODE_STREAM, MODE_BARS, MODE_SOLID, MODE_GRID} mode_e;
    typedef enum logic [1:0] {SRC_PATTERN, SRC_STREAM, SRC_SOLID} src_e;

    // ---------------- S0: counters ----------------
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    mode_e         mode_q;
    logic          run, at_origin;

    assign run       = en & ~reset;
    assign at_origin = (h_q == '0) && (v_q == '0);

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!en) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q    <= '0;
            v_q    <= '0;
            mode_q <= MODE_STREAM;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            if (run && at_origin) mode_q <= mode_e'(mode);
        end
    end

    logic hact, vact, den0, hs0, vs0;
    assign hact        = (h_q >= HW'(HA_START)) && (h_q < HW'(HA_END));
    assign vact        = (v_q >= VW'(VA_START)) && (v_q < VW'(VA_END));
    assign den0        = run & hact & vact;
    assign hs0         = run & (h_q < HW'(H_SYNC));
    assign vs0         = run & (v_q < VW'(V_SYNC));
    assign pix_req     = den0 & (mode_q == MODE_STREAM);
    assign frame_start = run & at_origin;

    // Pattern colours are full scale per channel, so 3 bits {R,G,B} describe them.
    logic [HW-1:0] x;
    logic [HW+2:0] x8;
    logic [3:0]    x_lo, y_lo;
    logic [2:0]    bar_idx, pat;
    src_e          src0;

    assign x    = h_q - HW'(HA_START);
    assign x8   = {x, 3'b000};
    assign x_lo = h_q[3:0] - 4'(HA_START);
    assign y_lo = v_q[3:0] - 4'(VA_START);

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x8 >= (HW+3)'(k * H_ACTIVE)) bar_idx = bar_idx + 3'd1;
        end
    end

    always_comb begin
        pat  = 3'b000;
        src0 = SRC_PATTERN;
        unique case (mode_q)
            MODE_STREAM: src0 = SRC_STREAM;
            MODE_SOLID:  src0 = SRC_SOLID;
            MODE_BARS:   pat  = bar_idx;
            MODE_GRID:   pat  = (x_lo == 4'd0 || y_lo == 4'd0) ? 3'b111 : 3'b000;
            default:     pat  = 3'b000;
        endcase
    end

    // ---------------- S1: timing/pattern stage ----------------
    logic s1_hs_q, s1_vs_q, s1_den_q;
    logic [2:0] s1_pat_q;
    src_e       s1_src_q;

    // NOTE: only control flops exist here (no memories), and each one is reset to its idle value.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_den_q <= 1'b0;
            s1_pat_q <= 3'b000;
            s1_src_q <= SRC_PATTERN;
        end else begin
            s1_hs_q  <= hs0;
            s1_vs_q  <= vs0;
            s1_den_q <= den0;
            s1_pat_q <= pat;
            s1_src_q <= src0;
        end
    end

    // ---------------- S2: pixel capture into output registers ----------------
    logic [OUT_W-1:0] wide_r, wide_g, wide_b, r_d, g_d, b_d;
    logic             uf_set, underflow_d;

    assign wide_r = OUT_W'(pix_data[15:11]) << (OUT_W - 5);
    assign wide_g = OUT_W'(pix_data[10:5])  << (OUT_W - 6);
    assign wide_b = OUT_W'(pix_data[4:0])   << (OUT_W - 5);

    always_comb begin
        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        uf_set = 1'b0;
        if (s1_den_q) begin
            unique case (s1_src_q)
                SRC_STREAM: begin
                    if (pix_valid) begin
                        r_d = wide_r;
                        g_d = wide_g;
                        b_d = wide_b;
                    end else begin
                        uf_set = 1'b1;
                    end
                end
                SRC_SOLID: begin
                    r_d = wide_r;
                    g_d = wide_g;
                    b_d = wide_b;
                end
                default: begin
                    r_d = {OUT_W{s1_pat_q[2]}};
                    g_d = {OUT_W{s1_pat_q[1]}};
                    b_d = {OUT_W{s1_pat_q[0]}};
                end
            endcase
        end
    end

    // A missing pixel wins over a simultaneous clear request.
    assign underflow_d = uf_set | (underflow & ~underflow_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_r     <= '0;
            lcd_g     <= '0;
            lcd_b     <= '0;
            lcd_hsync <= ~HS_POL;
            lcd_vsync <= ~VS_POL;
            lcd_den   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            lcd_r     <= r_d;
            lcd_g     <= g_d;
            lcd_b     <= b_d;
            lcd_hsync <= s1_hs_q ? HS_POL : ~HS_POL;
            lcd_vsync <= s1_vs_q ? VS_POL : ~VS_POL;
            lcd_den   <= s1_den_q;
            underflow <= underflow_d;
        end
    end

endmodule

// File: tb/tb_lcd_timing_out.sv
// Randomized bench for lcd_timing_out against a cycle-indexed reference model
// (position derived from elapsed enabled cycles), with a second inverted-polarity instance.
module tb_lcd_timing_out;

    localparam int HS = 4, HB = 3, HA = 32, HF = 2;
    localparam int VS = 2, VB = 1, VA = 20, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int N  = 7000;

    logic        clk = 1'b0;
    logic        reset, en, pix_valid, underflow_clr;
    logic [1:0]  mode;
    logic [15:0] pix_data;
    logic        pix_req, frame_start, underflow, lcd_hsync, lcd_vsync, lcd_den;
    logic [7:0]  lcd_r, lcd_g, lcd_b;
    logic        pix_req2, frame_start2, underflow2, lcd_hsync2, lcd_vsync2, lcd_den2;
    logic [7:0]  lcd_r2, lcd_g2, lcd_b2;

    always #5 clk = ~clk;

    lcd_timing_out #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .OUT_W(8), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .pix_req(pix_req),
        .pix_data(pix_data), .pix_valid(pix_valid), .frame_start(frame_start),
        .underflow(underflow), .underflow_clr(underflow_clr),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_den(lcd_den));

    lcd_timing_out #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .OUT_W(8), .HS_POL(1'b1), .VS_POL(1'b1)) dut_pol (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .pix_req(pix_req2),
        .pix_data(pix_data), .pix_valid(pix_valid), .frame_start(frame_start2),
        .underflow(underflow2), .underflow_clr(underflow_clr),
        .lcd_r(lcd_r2), .lcd_g(lcd_g2), .lcd_b(lcd_b2),
        .lcd_hsync(lcd_hsync2), .lcd_vsync(lcd_vsync2), .lcd_den(lcd_den2));

    // kind: 0 black, 1 stream, 2 solid, 3 pattern (rgb known immediately)
    typedef struct {
        bit          hs, vs, den, req;
        int          kind;
        logic [23:0] rgb;
    } rec_t;

    rec_t rec [0:N+2];
    int   n_cmp = 0, n_err = 0, cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [23:0] widen(input logic [15:0] p);
        return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
    endfunction

    function automatic rec_t idle_rec();
        rec_t r;
        r.hs = 0; r.vs = 0; r.den = 0; r.req = 0; r.kind = 0; r.rgb = 24'h0;
        return r;
    endfunction

    initial begin
        int   t, h, v, x, y, idx, cur_mode;
        bit   run, run_prev, uf, fs_exp;
        rec_t o;

        reset = 1'b1; en = 1'b1; mode = 2'd0; pix_data = '0;
        pix_valid = 1'b0; underflow_clr = 1'b0;
        t = 0; run_prev = 0; uf = 0; cur_mode = 0;
        rec[0] = idle_rec();
        rec[1] = idle_rec();

        for (int k = 2; k < N; k++) begin
            @(negedge clk);
            cyc = k;
            reset         = (k < 5) || (k >= 6000 && k < 6002);
            en            = !((k >= 5400 && k < 5406) || (k > 6100 && ($urandom % 300) == 0));
            mode          = (k < 1500) ? 2'd0 : (k < 3200) ? 2'd1 : (k < 4200) ? 2'd3 :
                            (k < 5200) ? 2'd2 : 2'd0;
            pix_data      = 16'($urandom);
            pix_valid     = ($urandom % 40) != 0;
            underflow_clr = ($urandom % 150) == 0;
            #1;

            run = en && !reset;
            t   = run_prev ? t + 1 : 0;
            h   = t % HT;
            v   = (t / HT) % VT;
            x   = h - (HS + HB);
            y   = v - (VS + VB);

            rec[k] = idle_rec();
            if (run) begin
                rec[k].hs  = (h < HS);
                rec[k].vs  = (v < VS);
                rec[k].den = (x >= 0 && x < HA && y >= 0 && y < VA);
                rec[k].req = rec[k].den && cur_mode == 0;
                if (rec[k].den) begin
                    case (cur_mode)
                        0: rec[k].kind = 1;
                        2: rec[k].kind = 2;
                        1: begin
                            idx = x * 8 / HA;
                            rec[k].kind = 3;
                            rec[k].rgb  = {(idx & 4) != 0 ? 8'hFF : 8'h00,
                                           (idx & 2) != 0 ? 8'hFF : 8'h00,
                                           (idx & 1) != 0 ? 8'hFF : 8'h00};
                        end
                        default: begin
                            rec[k].kind = 3;
                            rec[k].rgb  = (x % 16 == 0 || y % 16 == 0) ? 24'hFFFFFF : 24'h0;
                        end
                    endcase
                end
            end
            fs_exp = run && h == 0 && v == 0;

            if (k > 2) begin
                o = rec[k-2];
                check("pix_req", 32'(pix_req), 32'(rec[k].req));
                check("frame_start", 32'(frame_start), 32'(fs_exp));
                check("underflow", 32'(underflow), 32'(uf));
                check("pins{hs,vs,den,r,g,b}",
                      32'({lcd_hsync, lcd_vsync, lcd_den, lcd_r, lcd_g, lcd_b}),
                      32'({~o.hs, ~o.vs, o.den, o.rgb}));
                check("inv_pol_sync", 32'({lcd_hsync2, lcd_vsync2}), 32'({o.hs, o.vs}));
            end

            // Data for the previous request arrives now.
            if (rec[k-1].kind == 1) rec[k-1].rgb = pix_valid ? widen(pix_data) : 24'h0;
            if (rec[k-1].kind == 2) rec[k-1].rgb = widen(pix_data);

            if (reset)                             uf = 0;
            else if (rec[k-1].req && !pix_valid)  uf = 1;
            else if (underflow_clr)               uf = 0;

            if (reset) rec[k-1] = idle_rec();

            if (reset)                        cur_mode = 0;
            else if (run && h == 0 && v == 0) cur_mode = int'(mode);
            run_prev = run;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
